// File: rtl/comp_operand_sequencer.sv
// rtl/comp_operand_sequencer.sv - tagged operand sequencer feeding a combinational comparator
//
// Purpose:
//   Accepts tagged operand pairs over valid/ready and queues them in a small
//   FIFO. A three-state FSM pops one pair at a time. It holds the pair on the
//   registered src1/src2 outputs for one DRIVE cycle, then samples the
//   comparator's compOut at the end of that cycle. The sampled result and the
//   tag are returned over valid/ready. Results leave in FIFO order.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               operand request handshake (in_ready = !full)
//   in_src1, in_src2, in_tag        operand pair and request tag
//   src1, src2                      registered operands to the comparator
//   compOut                         comparator verdict: 00 eq, 01 gt, 10 lt
//   out_valid/out_ready             result handshake
//   out_result, out_tag             captured verdict and its tag
//   busy                            FIFO non-empty or FSM not idle
//   stats_clr, cnt_eq/gt/lt         only with COMP_SEQ_STATS_EN: saturating
//                                   per-class verdict counters, sync clear
//
// Configuration:
//   COMP_SEQ_STATS_EN  when defined, adds the verdict statistics counters.

module comp_operand_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] src1,
  output logic [WIDTH-1:0] src2,
  input  logic [1:0]       compOut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_result,
  output logic [TAG_W-1:0] out_tag,
`ifdef COMP_SEQ_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      cnt_eq,
  output logic [15:0]      cnt_gt,
  output logic [15:0]      cnt_lt,
`endif
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH + TAG_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head_entry;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign head_entry = mem_q[rd_ptr_q];

  // Storage carries no reset: emptiness is defined purely by the count, so
  // stale words left behind after a reset can never be popped.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_src1, in_src2, in_tag};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // A pop and a push in the same cycle leave the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   capture;
  logic   retire;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // src1/src2 have been stable for a full cycle, so compOut has settled.
        capture = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          retire = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand and result registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] src1_q, src2_q;
  logic [TAG_W-1:0] tag_q;
  logic             out_valid_q;
  logic [1:0]       out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  // Operands keep their last values when nothing is popped, so the
  // comparator input does not toggle while the block is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1_q <= '0;
      src2_q <= '0;
      tag_q  <= '0;
    end else if (pop) begin
      src1_q <= head_entry[EW-1 -: WIDTH];
      src2_q <= head_entry[TAG_W +: WIDTH];
      tag_q  <= head_entry[TAG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= 2'b00;
      out_tag_q    <= '0;
    end else begin
      if (capture) begin
        out_valid_q  <= 1'b1;
        out_result_q <= compOut;
        out_tag_q    <= tag_q;
      end else if (retire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign src1       = src1_q;
  assign src2       = src2_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = !fifo_empty || (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Optional verdict statistics
  // ---------------------------------------------------------------------------
`ifdef COMP_SEQ_STATS_EN
  logic [15:0] cnt_eq_q, cnt_gt_q, cnt_lt_q;
  logic [15:0] cnt_eq_d, cnt_gt_d, cnt_lt_d;

  // compOut=11 is not a defined verdict and lands in no bucket.
  always_comb begin
    cnt_eq_d = cnt_eq_q;
    cnt_gt_d = cnt_gt_q;
    cnt_lt_d = cnt_lt_q;
    if (stats_clr) begin
      cnt_eq_d = '0;
      cnt_gt_d = '0;
      cnt_lt_d = '0;
    end else if (capture) begin
      unique case (compOut)
        2'b00: if (cnt_eq_q != 16'hFFFF) cnt_eq_d = cnt_eq_q + 16'd1;
        2'b01: if (cnt_gt_q != 16'hFFFF) cnt_gt_d = cnt_gt_q + 16'd1;
        2'b10: if (cnt_lt_q != 16'hFFFF) cnt_lt_d = cnt_lt_q + 16'd1;
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_eq_q <= '0;
      cnt_gt_q <= '0;
      cnt_lt_q <= '0;
    end else begin
      cnt_eq_q <= cnt_eq_d;
      cnt_gt_q <= cnt_gt_d;
      cnt_lt_q <= cnt_lt_d;
    end
  end

  assign cnt_eq = cnt_eq_q;
  assign cnt_gt = cnt_gt_q;
  assign cnt_lt = cnt_lt_q;
`endif

endmodule

// File: tb/tb_comp_operand_sequencer.sv
// tb/tb_comp_operand_sequencer.sv - directed bench for comp_operand_sequencer
module tb_comp_operand_sequencer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_src1, in_src2;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] src1, src2;
  logic [1:0]       compOut;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic             comp_force;
`ifdef COMP_SEQ_STATS_EN
  logic             stats_clr;
  logic [15:0]      cnt_eq, cnt_gt, cnt_lt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Comparator model; comp_force injects the undefined 11 verdict.
  assign compOut = comp_force ? 2'b11 :
                   (src1 == src2) ? 2'b00 :
                   (src1 > src2)  ? 2'b01 : 2'b10;

  comp_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .src1(src1), .src2(src2), .compOut(compOut),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
`ifdef COMP_SEQ_STATS_EN
    .stats_clr(stats_clr), .cnt_eq(cnt_eq), .cnt_gt(cnt_gt), .cnt_lt(cnt_lt),
`endif
    .busy(busy)
  );

  task automatic set_in(input logic v, input int a, input int b, input int t);
    in_valid = v;
    in_src1  = WIDTH'(a);
    in_src2  = WIDTH'(b);
    in_tag   = TAG_W'(t);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    comp_force = 1'b0;
    set_in(1'b0, 0, 0, 0);
`ifdef COMP_SEQ_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 2'b00 || out_tag !== '0)
      begin errors++; $display("FAIL reset_out: valid=%b result=%b tag=%h want 0/00/0", out_valid, out_result, out_tag); end
    checks++;
    if (src1 !== '0 || src2 !== '0)
      begin errors++; $display("FAIL reset_src: src1=%h src2=%h want 0/0", src1, src2); end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_flags: busy=%b in_ready=%b want 0/1", busy, in_ready); end
`ifdef COMP_SEQ_STATS_EN
    checks++;
    if (cnt_eq !== 16'd0 || cnt_gt !== 16'd0 || cnt_lt !== 16'd0)
      begin errors++; $display("FAIL reset_stats: eq=%0d gt=%0d lt=%0d want 0/0/0", cnt_eq, cnt_gt, cnt_lt); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    set_in(1'b1, 1, 5, 3);
    @(negedge clk);
    set_in(1'b0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_t1: out_valid=%b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || src1 !== 32'd1 || src2 !== 32'd5)
      begin errors++; $display("FAIL lat_drive: valid=%b src1=%0d src2=%0d want 0/1/5", out_valid, src1, src2); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 2'b10 || out_tag !== 4'd3)
      begin errors++; $display("FAIL lat_t3: valid=%b result=%b tag=%0d want 1/10/3", out_valid, out_result, out_tag); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL lat_retire: valid=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    set_in(1'b1, 10, 2, 1);
    @(negedge clk);
    set_in(1'b1, 7, 7, 2);
    @(negedge clk);
    set_in(1'b0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_n2: out_valid=%b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 2'b01 || out_tag !== 4'd1)
      begin errors++; $display("FAIL b2b_first: valid=%b result=%b tag=%0d want 1/01/1", out_valid, out_result, out_tag); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: out_valid=%b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 2'b00 || out_tag !== 4'd2)
      begin errors++; $display("FAIL b2b_second: valid=%b result=%b tag=%0d want 1/00/2", out_valid, out_result, out_tag); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL b2b_idle: valid=%b busy=%b want 0/0", out_valid, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_compout_11();
    comp_force = 1'b1;
    set_in(1'b1, 4, 4, 9);
    @(negedge clk);
    set_in(1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 2'b11 || out_tag !== 4'd9)
      begin errors++; $display("FAIL cmp11: valid=%b result=%b tag=%0d want 1/11/9", out_valid, out_result, out_tag); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    comp_force = 1'b0;
  endtask

  task automatic test_full();
    int s1 [6] = '{1, 6, 9, 6, 2, 8};
    logic [1:0] exp_res [6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    int idx = 0;
    int nres = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 8) out_ready = 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if (nres >= 6) begin
          errors++; $display("FAIL full_extra: result %0d tag=%0d beyond 6 expected", nres, out_tag);
        end else if (out_result !== exp_res[nres] || out_tag !== TAG_W'(nres + 4)) begin
          errors++; $display("FAIL full_order[%0d]: result=%b tag=%0d want %b/%0d", nres, out_result, out_tag, exp_res[nres], nres + 4);
        end
        nres++;
      end
      if (cyc == 5 || cyc == 7) begin
        checks++;
        if (in_ready !== 1'b0 || idx != 5)
          begin errors++; $display("FAIL full_stall@%0d: in_ready=%b accepted=%0d want 0/5", cyc, in_ready, idx); end
      end
      if (idx < 6) begin
        set_in(1'b1, s1[idx], 6, idx + 4);
        if (in_ready) idx++;
      end else begin
        set_in(1'b0, 0, 0, 0);
      end
    end
    checks++;
    if (nres != 6 || idx != 6 || busy !== 1'b0)
      begin errors++; $display("FAIL full_drain: results=%0d accepted=%0d busy=%b want 6/6/0", nres, idx, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_hold_stable();
    bit seen = 0;
    out_ready = 1'b0;
    set_in(1'b1, 20, 30, 10);
    @(negedge clk);
    set_in(1'b0, 0, 0, 0);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL hold_wait: out_valid=%b want 1 within 10 cycles", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 2'b10 || out_tag !== 4'hA)
        begin errors++; $display("FAIL hold_stable[%0d]: valid=%b result=%b tag=%h want 1/10/a", i, out_valid, out_result, out_tag); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || src1 !== 32'd20 || src2 !== 32'd30)
      begin errors++; $display("FAIL hold_retire: valid=%b busy=%b src1=%0d src2=%0d want 0/0/20/30", out_valid, busy, src1, src2); end
  endtask

  task automatic test_reset_in_drive();
    bit seen = 0;
    bit leaked = 0;
    out_ready = 1'b0;
    set_in(1'b1, 5, 1, 1);
    @(negedge clk);
    set_in(1'b0, 0, 0, 0);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_wait: out_valid=%b want 1 within 10 cycles", out_valid); end
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, k + 2, 3, k + 2);
      @(negedge clk);
    end
    set_in(1'b0, 0, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || src1 !== 32'd2)
      begin errors++; $display("FAIL rst_predrive: valid=%b busy=%b src1=%0d want 0/1/2", out_valid, busy, src1); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (src1 !== '0 || src2 !== '0 || out_valid !== 1'b0 || out_result !== 2'b00 ||
        out_tag !== '0 || busy !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_async: src1=%h src2=%h valid=%b result=%b tag=%h busy=%b in_ready=%b want all reset", src1, src2, out_valid, out_result, out_tag, busy, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) leaked = 1;
    end
    checks++;
    if (leaked) begin errors++; $display("FAIL rst_no_emit: valid=%b busy=%b want 0/0 after release", out_valid, busy); end
    out_ready = 1'b0;
  endtask

`ifdef COMP_SEQ_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++;
    if (cnt_eq !== 16'd0 || cnt_gt !== 16'd0 || cnt_lt !== 16'd0)
      begin errors++; $display("FAIL stats_clr0: eq=%0d gt=%0d lt=%0d want 0/0/0", cnt_eq, cnt_gt, cnt_lt); end
    out_ready = 1'b1;
    comp_force = 1'b1;
    set_in(1'b1, 3, 3, 0);
    @(negedge clk);
    set_in(1'b0, 0, 0, 0);
    repeat (6) @(negedge clk);
    comp_force = 1'b0;
    checks++;
    if (cnt_eq !== 16'd0 || cnt_gt !== 16'd0 || cnt_lt !== 16'd0)
      begin errors++; $display("FAIL stats_11: eq=%0d gt=%0d lt=%0d want 0/0/0", cnt_eq, cnt_gt, cnt_lt); end
    set_in(1'b1, 7, 7, 1);
    @(negedge clk);
    set_in(1'b1, 9, 1, 2);
    @(negedge clk);
    set_in(1'b1, 1, 9, 3);
    @(negedge clk);
    set_in(1'b0, 0, 0, 0);
    repeat (10) @(negedge clk);
    checks++;
    if (cnt_eq !== 16'd1 || cnt_gt !== 16'd1 || cnt_lt !== 16'd1)
      begin errors++; $display("FAIL stats_count: eq=%0d gt=%0d lt=%0d want 1/1/1", cnt_eq, cnt_gt, cnt_lt); end
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++;
    if (cnt_eq !== 16'd0 || cnt_gt !== 16'd0 || cnt_lt !== 16'd0)
      begin errors++; $display("FAIL stats_clr1: eq=%0d gt=%0d lt=%0d want 0/0/0", cnt_eq, cnt_gt, cnt_lt); end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_compout_11();
    test_full();
    test_hold_stable();
    test_reset_in_drive();
`ifdef COMP_SEQ_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
